mem_writeback: RTL and testbench
================================

Name: mem_writeback

Overview:
- Final (third) pipeline stage, directly downstream of the execute stage.
- Consumes execute's registered write-back bundle: result, destination register, memory-op flags, funct3, address, byte strobes, store data.
- Performs data-memory load/store over a req/ack handshake, aligns and extends load data, and drives the register-file write port.
- Asserts wb_stall to freeze fetch/execute while a memory transaction is outstanding.

Parameters:
- ADDR_W, 32, width of dmem_addr and ex_addr.
- RESET_STRB, 4'h0, value driven on dmem_wstrb in reset and idle.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute presents a valid op this cycle
- ex_alu_to_reg  in  1  op writes a destination register
- ex_mem_to_reg  in  1  op is a load
- ex_mem_write  in  1  op is a store
- ex_result  in  32  ALU/LUI/JAL result
- ex_dest_reg_sel  in  5  destination register index
- ex_funct3  in  3  load/store size: 0 B, 1 H, 2 W, 4 BU, 5 HU
- ex_addr  in  ADDR_W  effective load/store byte address
- ex_write_byte  in  4  store byte strobes
- ex_write_data  in  32  store data, lane-replicated
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  ADDR_W  word-aligned address {ex_addr[ADDR_W-1:2],2'b00}
- dmem_wstrb  out  4  store strobes
- dmem_wdata  out  32  store data
- dmem_ack  in  1  memory completes the transaction (rdata valid for loads)
- dmem_rdata  in  32  load word
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write index
- rf_wdata  out  32  register-file write data
- wb_stall  out  1  upstream hold
- misaligned  out  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Reset (async, reset low): state IDLE; all outputs 0; dmem_wstrb = RESET_STRB. An ack arriving after reset is ignored.
- Accept condition: ex_valid && !wb_stall.
- FSM states:
  - IDLE → LOAD: accepted op with ex_mem_to_reg.
  - IDLE → STORE: accepted op with ex_mem_write.
  - LOAD/STORE → IDLE: on the cycle dmem_ack=1 is sampled.
- Store priority: if ex_mem_write and ex_mem_to_reg are both set, treat the op as a store.
- ALU-only op (ex_alu_to_reg, no memory flags): next cycle rf_we=1, rf_waddr=ex_dest_reg_sel, rf_wdata=ex_result; state stays IDLE. Latency 1.
- Memory request signals:
  - dmem_req/we/addr/wstrb/wdata are registered and go valid the cycle after acceptance.
  - They stay stable until the ack cycle; dmem_req deasserts the cycle after ack.
- wb_stall = (state != IDLE) && !dmem_ack (combinational). A new op can be accepted in the ack cycle (back-to-back), and its request issues the following cycle.
- Load completion: on ack, register the aligned data and pulse rf_we for exactly one cycle (load-to-rf latency 1 after ack). Alignment by ex_addr[1:0], latched at accept:
  - LB: byte at offset, sign-extended.
  - LBU: byte at offset, zero-extended.
  - LH: half at addr[1], sign-extended.
  - LHU: half at addr[1], zero-extended.
  - LW: full word.
  - funct3 3/6/7: rf_wdata = 0 (rf_we still pulses).
- Stores: no rf write.
- rf_we is never asserted when the destination is x0 (rf_waddr=0).
- rf_we is a single-cycle pulse; rf_waddr/rf_wdata hold their last value otherwise.
- dmem_ack in IDLE is ignored.
- ex_valid=0: no state change; rf_we=0 next cycle.

Optional Feature:
- Macro: MEM_WB_MISALIGN_CHECK_EN.
- Defined:
  - Condition: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - Response: no dmem_req, no rf write, state stays IDLE; misaligned pulses 1 cycle after acceptance.
- Undefined:
  - misaligned tied 0; the access proceeds with the truncated word address.

Test Plan:
- Reset mid-LOAD (req high, no ack), then release → dmem_req=0, rf_we=0, wb_stall=0; a later stray ack causes no rf write.
- ALU op, dest=5, result=0x1234 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234. Same op with dest=0 → rf_we stays 0.
- LB at addr 0x103, rdata=0x80FF_0000, ack after 3 cycles → wb_stall high for 3 cycles, dmem_addr=0x100; rf_wdata=0xFFFF_FF80 one cycle after ack. The same access as LBU → 0x0000_0080.
- LH at 0x202, rdata=0x8001_7FFF → 0xFFFF_8001; LHU → 0x0000_8001; LW at 0x200 → 0x8001_7FFF.
- SB at 0x301, wstrb=0010, data=0xAAAA_AAAA, ack same cycle as req → dmem_we=1, no rf_we. A load accepted in the ack cycle issues its req the next cycle.
- With MEM_WB_MISALIGN_CHECK_EN: LW at 0x402 → misaligned=1 for one cycle, dmem_req never asserted. Without the macro: dmem_addr=0x400 and the load completes normally.

Source files
------------

// File: rtl/mem_writeback_if.sv
// Data-memory request/acknowledge bus between the write-back stage and data memory.
// master: the write-back stage issuing requests; slave: the memory answering them.
interface mem_writeback_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        wstrb;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, wstrb, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wstrb, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_writeback.sv
// Final pipeline stage: data-memory load/store over a req/ack handshake,
// load alignment/extension and the register-file write port.
// Optional misaligned-access trap is enabled by defining MEM_WB_MISALIGN_CHECK_EN;
// without it the misaligned output is tied low and accesses use the truncated word address.
module mem_writeback #(
  parameter int         ADDR_W     = 32,
  parameter logic [3:0] RESET_STRB = 4'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_alu_to_reg,
  input  logic              ex_mem_to_reg,
  input  logic              ex_mem_write,
  input  logic [31:0]       ex_result,
  input  logic [4:0]        ex_dest_reg_sel,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [3:0]        ex_write_byte,
  input  logic [31:0]       ex_write_data,
  mem_writeback_if.master   dmem,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              wb_stall,
  output logic              misaligned
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        ld_funct3_q, ld_funct3_d;
  logic [1:0]        ld_offset_q, ld_offset_d;
  logic [4:0]        ld_dest_q, ld_dest_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [31:0]       rf_wdata_q, rf_wdata_d;
  // An ALU result accepted in the same cycle a load completes is parked here
  // for one cycle so the two register writes retire in program order.
  logic              pend_valid_q, pend_valid_d;
  logic [4:0]        pend_dest_q, pend_dest_d;
  logic [31:0]       pend_data_q, pend_data_d;

  logic accept;
  logic is_store;
  logic is_load;
  logic is_alu;
  logic load_done;
  logic access_misaligned;

  // Pick the addressed byte/half out of the returned word and extend it.
  function automatic logic [31:0] align_load(input logic [2:0]  f3,
                                             input logic [1:0]  off,
                                             input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd2:    r = word;
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign wb_stall = (state_q != ST_IDLE) && !dmem.ack;
  assign accept   = ex_valid && !wb_stall;
  // Store wins when both memory flags are set.
  assign is_store = ex_mem_write;
  assign is_load  = ex_mem_to_reg && !ex_mem_write;
  assign is_alu   = ex_alu_to_reg && !ex_mem_to_reg && !ex_mem_write;
  assign load_done = (state_q == ST_LOAD) && dmem.ack;

`ifdef MEM_WB_MISALIGN_CHECK_EN
  logic misal_q, misal_d;
  assign access_misaligned = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                             ((ex_funct3 == 3'd2) && (ex_addr[1:0] != 2'b00));
  assign misaligned = misal_q;
`else
  assign access_misaligned = 1'b0;
  assign misaligned = 1'b0;
`endif

  // Next-state: retire the outstanding access on ack, then accept a new op.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    ld_funct3_d  = ld_funct3_q;
    ld_offset_d  = ld_offset_q;
    ld_dest_d    = ld_dest_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    pend_valid_d = 1'b0;
    pend_dest_d  = pend_dest_q;
    pend_data_d  = pend_data_q;
`ifdef MEM_WB_MISALIGN_CHECK_EN
    misal_d      = 1'b0;
`endif

    if ((state_q != ST_IDLE) && dmem.ack) begin
      state_d = ST_IDLE;
      req_d   = 1'b0;
      we_d    = 1'b0;
      wstrb_d = RESET_STRB;
    end

    if (load_done) begin
      rf_we_d    = (ld_dest_q != 5'd0);
      rf_waddr_d = ld_dest_q;
      rf_wdata_d = align_load(ld_funct3_q, ld_offset_q, dmem.rdata);
    end else if (pend_valid_q) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pend_dest_q;
      rf_wdata_d = pend_data_q;
    end

    if (accept) begin
      if ((is_load || is_store) && access_misaligned) begin
`ifdef MEM_WB_MISALIGN_CHECK_EN
        misal_d = 1'b1;
`endif
      end else if (is_store) begin
        state_d = ST_STORE;
        req_d   = 1'b1;
        we_d    = 1'b1;
        addr_d  = {ex_addr[ADDR_W-1:2], 2'b00};
        wstrb_d = ex_write_byte;
        wdata_d = ex_write_data;
      end else if (is_load) begin
        state_d     = ST_LOAD;
        req_d       = 1'b1;
        we_d        = 1'b0;
        addr_d      = {ex_addr[ADDR_W-1:2], 2'b00};
        wstrb_d     = RESET_STRB;
        ld_funct3_d = ex_funct3;
        ld_offset_d = ex_addr[1:0];
        ld_dest_d   = ex_dest_reg_sel;
      end else if (is_alu && (ex_dest_reg_sel != 5'd0)) begin
        if (load_done || pend_valid_q) begin
          pend_valid_d = 1'b1;
          pend_dest_d  = ex_dest_reg_sel;
          pend_data_d  = ex_result;
        end else begin
          rf_we_d    = 1'b1;
          rf_waddr_d = ex_dest_reg_sel;
          rf_wdata_d = ex_result;
        end
      end
    end
  end

  // State and registered outputs, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wstrb_q      <= RESET_STRB;
      wdata_q      <= 32'd0;
      ld_funct3_q  <= 3'd0;
      ld_offset_q  <= 2'd0;
      ld_dest_q    <= 5'd0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= 5'd0;
      rf_wdata_q   <= 32'd0;
      pend_valid_q <= 1'b0;
      pend_dest_q  <= 5'd0;
      pend_data_q  <= 32'd0;
`ifdef MEM_WB_MISALIGN_CHECK_EN
      misal_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      ld_funct3_q  <= ld_funct3_d;
      ld_offset_q  <= ld_offset_d;
      ld_dest_q    <= ld_dest_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      pend_valid_q <= pend_valid_d;
      pend_dest_q  <= pend_dest_d;
      pend_data_q  <= pend_data_d;
`ifdef MEM_WB_MISALIGN_CHECK_EN
      misal_q      <= misal_d;
`endif
    end
  end

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wstrb = wstrb_q;
  assign dmem.wdata = wdata_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

  // x0 is hard-wired zero, so a write to it must never be signalled.
  always @(posedge clk) begin
    if (reset) assert (!(rf_we_q && (rf_waddr_q == 5'd0)));
  end

  // An unanswered request holds its address until acknowledged.
  always @(posedge clk) begin
    if (reset && req_q && !dmem.ack) assert (req_d && (addr_d == addr_q));
  end

endmodule

// File: tb/tb_mem_writeback.sv
// Testbench for mem_writeback: directed timing cases followed by a randomized
// run checked against an in-order model of register-file writes.
// Misaligned-access expectations follow MEM_WB_MISALIGN_CHECK_EN.
module tb_mem_writeback;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0, ex_alu_to_reg = 1'b0, ex_mem_to_reg = 1'b0, ex_mem_write = 1'b0;
  logic [31:0] ex_result = '0;
  logic [4:0]  ex_dest_reg_sel = '0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_addr = '0;
  logic [3:0]  ex_write_byte = '0;
  logic [31:0] ex_write_data = '0;
  logic        rf_we, wb_stall, misaligned;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  mem_writeback_if #(.ADDR_W(ADDR_W)) dmem_bus ();

  mem_writeback #(.ADDR_W(ADDR_W), .RESET_STRB(4'h0)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_alu_to_reg(ex_alu_to_reg),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
    .ex_result(ex_result), .ex_dest_reg_sel(ex_dest_reg_sel),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_write_byte(ex_write_byte), .ex_write_data(ex_write_data),
    .dmem(dmem_bus),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_stall(wb_stall), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } rfw_t;
  rfw_t exp_q[$];

  // randomized-run memory model state
  bit          busy = 0;
  bit          op_store = 0;
  int          wait_cnt = 0;
  logic [2:0]  op_f3 = '0;
  logic [31:0] op_addr = '0;
  logic [4:0]  op_dest = '0;
  logic [3:0]  op_strb = '0;
  logic [31:0] op_wdata = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic alu, input logic m2r, input logic mw,
                               input logic [31:0] res, input logic [4:0] dest, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [3:0] wb, input logic [31:0] wd);
    ex_valid = valid;
    ex_alu_to_reg = alu;
    ex_mem_to_reg = m2r;
    ex_mem_write = mw;
    ex_result = res;
    ex_dest_reg_sel = dest;
    ex_funct3 = f3;
    ex_addr = addr;
    ex_write_byte = wb;
    ex_write_data = wd;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 3'd0, 32'd0, 4'd0, 32'd0);
  endtask

  // Expected register value for a load, from the size/sign rules.
  function automatic logic [31:0] loadModel(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] word);
    logic [31:0] byte_w;
    logic [31:0] half_w;
    byte_w = (word >> (8 * int'(off))) & 32'hFF;
    half_w = (word >> (16 * int'(off[1]))) & 32'hFFFF;
    case (f3)
      3'd0:    return (byte_w >= 32'h80) ? (byte_w | 32'hFFFF_FF00) : byte_w;
      3'd1:    return (half_w >= 32'h8000) ? (half_w | 32'hFFFF_0000) : half_w;
      3'd2:    return word;
      3'd4:    return byte_w;
      3'd5:    return half_w;
      default: return 32'd0;
    endcase
  endfunction

  task automatic doLoad(input string name, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rdata, input logic [4:0] dest, input int lat,
                        input logic [31:0] exp);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, dest, f3, addr, 4'd0, 32'd0);
    tick();
    idleInputs();
    checkOutput({name, "_req"}, dmem_bus.req, 1);
    checkOutput({name, "_we"}, dmem_bus.we, 0);
    checkOutput({name, "_addr"}, dmem_bus.addr, addr & 32'hFFFF_FFFC);
    for (int i = 0; i < lat; i++) begin
      checkOutput({name, "_stall"}, wb_stall, 1);
      checkOutput({name, "_req_hold"}, dmem_bus.req, 1);
      tick();
    end
    dmem_bus.ack = 1'b1;
    dmem_bus.rdata = rdata;
    #1;
    checkOutput({name, "_stall_ack"}, wb_stall, 0);
    tick();
    dmem_bus.ack = 1'b0;
    checkOutput({name, "_rf_we"}, rf_we, 1);
    checkOutput({name, "_rf_waddr"}, rf_waddr, dest);
    checkOutput({name, "_rf_wdata"}, rf_wdata, exp);
    checkOutput({name, "_req_drop"}, dmem_bus.req, 0);
    tick();
    checkOutput({name, "_rf_pulse"}, rf_we, 0);
  endtask

  // One cycle of the randomized run: check rf writes, answer memory, maybe issue an op.
  task automatic randomCycle(input bit allow_new);
    rfw_t        e;
    logic        valid, alu, m2r, mw;
    logic [2:0]  f3;
    logic [31:0] addr, res, wd;
    logic [4:0]  dest;
    logic [3:0]  wb;
    int          kind;

    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("rnd_rf_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("rnd_rf_waddr", rf_waddr, e.dest);
        checkOutput("rnd_rf_wdata", rf_wdata, e.data);
      end
    end
    checkOutput("rnd_misaligned", misaligned, 0);

    if (busy) begin
      checkOutput("rnd_req", dmem_bus.req, 1);
      checkOutput("rnd_we", dmem_bus.we, op_store);
      checkOutput("rnd_addr", dmem_bus.addr, op_addr & 32'hFFFF_FFFC);
      if (op_store) begin
        checkOutput("rnd_wstrb", dmem_bus.wstrb, op_strb);
        checkOutput("rnd_wdata", dmem_bus.wdata, op_wdata);
      end
      if (wait_cnt == 0) begin
        dmem_bus.ack = 1'b1;
        dmem_bus.rdata = $urandom;
        if (!op_store && op_dest != 5'd0)
          exp_q.push_back('{op_dest, loadModel(op_f3, op_addr[1:0], dmem_bus.rdata)});
        busy = 0;
      end else begin
        dmem_bus.ack = 1'b0;
        wait_cnt--;
      end
    end else begin
      checkOutput("rnd_req_idle", dmem_bus.req, 0);
      dmem_bus.ack = ($urandom_range(0, 7) == 0);
      dmem_bus.rdata = $urandom;
    end
    #1;
    checkOutput("rnd_stall", wb_stall, {31'd0, busy});

    kind = $urandom_range(0, 5);
    alu = 0; m2r = 0; mw = 0;
    f3 = 3'd0;
    dest = 5'($urandom_range(0, 31));
    res = $urandom;
    wb = 4'($urandom_range(0, 15));
    wd = $urandom;
    addr = $urandom;
    case (kind)
      0, 1: alu = 1;
      2: begin m2r = 1; alu = 1; f3 = 3'($urandom_range(0, 7)); end
      3: begin mw = 1; f3 = 3'($urandom_range(0, 2)); end
      4: begin m2r = 1; mw = 1; f3 = 3'($urandom_range(0, 2)); end
      default: ;
    endcase
    if (f3[1:0] == 2'b01) addr[0] = 1'b0;
    if (f3 == 3'd2) addr[1:0] = 2'b00;
    valid = allow_new && ($urandom_range(0, 3) != 0);
    applyStimulus(valid, alu, m2r, mw, res, dest, f3, addr, wb, wd);

    if (valid && !busy) begin
      if (mw) begin
        busy = 1; op_store = 1; wait_cnt = $urandom_range(0, 3);
        op_addr = addr; op_strb = wb; op_wdata = wd;
      end else if (m2r) begin
        busy = 1; op_store = 0; wait_cnt = $urandom_range(0, 3);
        op_addr = addr; op_f3 = f3; op_dest = dest;
      end else if (alu && dest != 5'd0) begin
        exp_q.push_back('{dest, res});
      end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    dmem_bus.ack = 1'b0;
    dmem_bus.rdata = 32'd0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req", dmem_bus.req, 0);
    checkOutput("rst_we", dmem_bus.we, 0);
    checkOutput("rst_wstrb", dmem_bus.wstrb, 0);
    checkOutput("rst_rf_we", rf_we, 0);
    checkOutput("rst_stall", wb_stall, 0);
    checkOutput("rst_misaligned", misaligned, 0);
    reset = 1'b1;
    tick();

    // ALU write and x0 suppression
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h1234, 5'd5, 3'd0, 32'd0, 4'd0, 32'd0);
    tick();
    idleInputs();
    checkOutput("alu_rf_we", rf_we, 1);
    checkOutput("alu_rf_waddr", rf_waddr, 5);
    checkOutput("alu_rf_wdata", rf_wdata, 32'h1234);
    tick();
    checkOutput("alu_rf_pulse", rf_we, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h1234, 5'd0, 3'd0, 32'd0, 4'd0, 32'd0);
    tick();
    idleInputs();
    checkOutput("alu_x0_rf_we", rf_we, 0);
    tick();
    checkOutput("alu_x0_rf_we2", rf_we, 0);

    // loads with alignment and extension
    doLoad("lb",  3'd0, 32'h103, 32'h80FF_0000, 5'd3, 3, 32'hFFFF_FF80);
    doLoad("lbu", 3'd4, 32'h103, 32'h80FF_0000, 5'd3, 3, 32'h0000_0080);
    doLoad("lh",  3'd1, 32'h202, 32'h8001_7FFF, 5'd4, 1, 32'hFFFF_8001);
    doLoad("lhu", 3'd5, 32'h202, 32'h8001_7FFF, 5'd4, 0, 32'h0000_8001);
    doLoad("lw",  3'd2, 32'h200, 32'h8001_7FFF, 5'd6, 2, 32'h8001_7FFF);
    doLoad("ld3", 3'd3, 32'h200, 32'h8001_7FFF, 5'd6, 0, 32'h0000_0000);

    // store acked with its request, load accepted back-to-back
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 5'd0, 3'd0, 32'h301, 4'b0010, 32'hAAAA_AAAA);
    tick();
    idleInputs();
    checkOutput("sb_req", dmem_bus.req, 1);
    checkOutput("sb_we", dmem_bus.we, 1);
    checkOutput("sb_addr", dmem_bus.addr, 32'h300);
    checkOutput("sb_wstrb", dmem_bus.wstrb, 4'b0010);
    checkOutput("sb_wdata", dmem_bus.wdata, 32'hAAAA_AAAA);
    dmem_bus.ack = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 5'd7, 3'd2, 32'h200, 4'd0, 32'd0);
    #1;
    checkOutput("sb_stall_ack", wb_stall, 0);
    tick();
    dmem_bus.ack = 1'b0;
    idleInputs();
    checkOutput("sb_no_rf", rf_we, 0);
    checkOutput("b2b_req", dmem_bus.req, 1);
    checkOutput("b2b_we", dmem_bus.we, 0);
    checkOutput("b2b_addr", dmem_bus.addr, 32'h200);
    dmem_bus.ack = 1'b1;
    dmem_bus.rdata = 32'h1234_5678;
    tick();
    dmem_bus.ack = 1'b0;
    checkOutput("b2b_rf_we", rf_we, 1);
    checkOutput("b2b_rf_wdata", rf_wdata, 32'h1234_5678);
    tick();

    // misaligned word load
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 5'd9, 3'd2, 32'h402, 4'd0, 32'd0);
    tick();
    idleInputs();
`ifdef MEM_WB_MISALIGN_CHECK_EN
    checkOutput("mis_flag", misaligned, 1);
    checkOutput("mis_req", dmem_bus.req, 0);
    checkOutput("mis_stall", wb_stall, 0);
    tick();
    checkOutput("mis_pulse", misaligned, 0);
    checkOutput("mis_req2", dmem_bus.req, 0);
    checkOutput("mis_rf_we", rf_we, 0);
    tick();
    checkOutput("mis_rf_we2", rf_we, 0);
`else
    checkOutput("mis_flag", misaligned, 0);
    checkOutput("mis_req", dmem_bus.req, 1);
    checkOutput("mis_addr", dmem_bus.addr, 32'h400);
    dmem_bus.ack = 1'b1;
    dmem_bus.rdata = 32'hCAFE_F00D;
    tick();
    dmem_bus.ack = 1'b0;
    checkOutput("mis_rf_we", rf_we, 1);
    checkOutput("mis_rf_wdata", rf_wdata, 32'hCAFE_F00D);
    tick();
`endif

    // reset in the middle of a load, then a stray ack
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 5'd8, 3'd2, 32'h500, 4'd0, 32'd0);
    tick();
    idleInputs();
    checkOutput("rstld_req_before", dmem_bus.req, 1);
    reset = 1'b0;
    #1;
    checkOutput("rstld_req_async", dmem_bus.req, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("rstld_req", dmem_bus.req, 0);
    checkOutput("rstld_stall", wb_stall, 0);
    checkOutput("rstld_rf_we", rf_we, 0);
    dmem_bus.ack = 1'b1;
    dmem_bus.rdata = 32'hDEAD_BEEF;
    #1;
    checkOutput("rstld_stall_stray", wb_stall, 0);
    tick();
    dmem_bus.ack = 1'b0;
    checkOutput("rstld_stray_rf", rf_we, 0);
    tick();
    checkOutput("rstld_stray_rf2", rf_we, 0);

    // randomized run against the in-order write model
    busy = 0;
    exp_q.delete();
    for (int i = 0; i < 600; i++) randomCycle(1'b1);
    for (int i = 0; i < 12; i++) randomCycle(1'b0);
    dmem_bus.ack = 1'b0;
    idleInputs();
    checkOutput("rnd_drain_queue", exp_q.size(), 0);
    checkOutput("rnd_drain_busy", {31'd0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
